// File: rtl/traffic_phase_ctrl.sv
// Actuated traffic-phase sequencer: ALLRED -> GREEN -> YELLOW with demand skip, gap-out and rest-in-green.
// Optional pedestrian service (PED_REQ / WALK) is built when macro TRAFFIC_PED_EN is defined.
module traffic_phase_ctrl #(
   parameter int N_PH  = 4,
   parameter int CW    = 6,
   parameter int YEL_T = 3,
   parameter int AR_T  = 1,
   parameter int MIN_G = 5
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      TICK,
   input  logic [N_PH-1:0]           DEMAND,
   input  logic [N_PH*CW-1:0]        GREEN_T,
`ifdef TRAFFIC_PED_EN
   input  logic                      PED_REQ,
   output logic                      WALK,
`endif
   output logic [$clog2(N_PH)-1:0]   PHASE,
   output logic [1:0]                STATE,
   output logic [N_PH-1:0]           GRN,
   output logic [N_PH-1:0]           YEL,
   output logic [CW-1:0]             REMAIN,
   output logic                      STEP
);

   localparam int PW = $clog2(N_PH);

   typedef enum logic [1:0] {
      ST_ALLRED = 2'b00,
      ST_GREEN  = 2'b01,
      ST_YELLOW = 2'b10
   } state_t;

   localparam logic [CW-1:0] ONE_D  = CW'(1);
   localparam logic [CW-1:0] ZERO_D = CW'(0);
   localparam logic [CW-1:0] SAT_D  = {CW{1'b1}};
   localparam logic [CW-1:0] MIN_D  = CW'(MIN_G);
   localparam logic [CW-1:0] YEL_D  = (YEL_T == 0) ? CW'(1) : CW'(YEL_T);
   localparam logic [CW-1:0] AR_D   = (AR_T == 0) ? CW'(1) : CW'(AR_T);
   localparam logic [PW-1:0] LAST_PH = PW'(N_PH - 1);
`ifdef TRAFFIC_PED_EN
   localparam logic [CW-1:0] EXT_D  = CW'(1 << (CW - 2));
`endif

   // A zero duration would never expire, so it is served as a single tick.
   function automatic logic [CW-1:0] clamp_dur(input logic [CW-1:0] d);
      logic [CW-1:0] r;
      if (d == ZERO_D) begin
         r = ONE_D;
      end else begin
         r = d;
      end
      return r;
   endfunction

   function automatic logic [N_PH-1:0] onehot(input logic [PW-1:0] idx);
      logic [N_PH-1:0] v;
      for (int i = 0; i < N_PH; i++) begin
         v[i] = (idx == PW'(i));
      end
      return v;
   endfunction

   // First demanded phase after cur (cyclic); plain cur+1 when nothing is demanded.
   function automatic logic [PW-1:0] pick_next(input logic [PW-1:0] cur,
                                               input logic [N_PH-1:0] dem);
      logic [PW-1:0] res;
      logic          found;
      int            idx;
      res   = PW'((int'(cur) + 1) % N_PH);
      found = 1'b0;
      for (int k = 1; k <= N_PH; k++) begin
         idx = (int'(cur) + k) % N_PH;
         if (!found && dem[idx]) begin
            res   = PW'(idx);
            found = 1'b1;
         end else begin
            res   = res;
            found = found;
         end
      end
      return res;
   endfunction

   state_t          state_r, state_s;
   logic [PW-1:0]   phase_r, phase_s, pick_s;
   logic [CW-1:0]   remain_r, remain_s;
   logic [CW-1:0]   elapsed_r, elapsed_s, el_inc_s;
   logic [N_PH-1:0] grn_r, grn_s, yel_r, yel_s;
   logic            step_r, step_s;
   logic            expire_s, min_ok_s, own_s, other_s, rest_s, gap_s, cut_s;
   logic [CW-1:0]   ar_load_s;
`ifdef TRAFFIC_PED_EN
   logic            ped_lat_r, ped_lat_s;
   logic            svc_r, svc_s;
   logic            walk_r, walk_s;
`endif

   // Next-state, countdown and lamp decode for the phase sequencer.
   always_comb begin
      state_s   = state_r;
      phase_s   = phase_r;
      remain_s  = remain_r;
      elapsed_s = elapsed_r;
      expire_s  = TICK && (remain_r == ONE_D);
      el_inc_s  = (elapsed_r == SAT_D) ? SAT_D : (elapsed_r + ONE_D);
      min_ok_s  = (el_inc_s >= MIN_D);
      own_s     = DEMAND[phase_r];
      other_s   = |(DEMAND & ~onehot(phase_r));
      rest_s    = own_s && !other_s;
      gap_s     = min_ok_s && !own_s && other_s;
      pick_s    = pick_next(phase_r, DEMAND);
`ifdef TRAFFIC_PED_EN
      cut_s     = ped_lat_r && min_ok_s;
      ar_load_s = ped_lat_r ? (AR_D + EXT_D) : AR_D;
`else
      cut_s     = 1'b0;
      ar_load_s = AR_D;
`endif

      case (state_r)
         ST_ALLRED: begin
            if (expire_s) begin
               state_s   = ST_GREEN;
               phase_s   = pick_s;
               remain_s  = clamp_dur(GREEN_T[int'(pick_s)*CW +: CW]);
               elapsed_s = ZERO_D;
            end else if (TICK) begin
               remain_s  = remain_r - ONE_D;
            end else begin
               remain_s  = remain_r;
            end
         end
         ST_GREEN: begin
            if (TICK) begin
               elapsed_s = el_inc_s;
               if (gap_s || cut_s || (expire_s && !rest_s)) begin
                  state_s  = ST_YELLOW;
                  remain_s = YEL_D;
               end else if (expire_s) begin
                  // Rest in green: hold at 1 so the next tick re-evaluates demand.
                  remain_s = ONE_D;
               end else begin
                  remain_s = remain_r - ONE_D;
               end
            end else begin
               elapsed_s = elapsed_r;
            end
         end
         ST_YELLOW: begin
            if (expire_s) begin
               state_s  = ST_ALLRED;
               remain_s = ar_load_s;
            end else if (TICK) begin
               remain_s = remain_r - ONE_D;
            end else begin
               remain_s = remain_r;
            end
         end
         default: begin
            state_s   = ST_ALLRED;
            phase_s   = LAST_PH;
            remain_s  = AR_D;
            elapsed_s = ZERO_D;
         end
      endcase

      if (state_s == ST_GREEN) begin
         grn_s = onehot(phase_s);
      end else begin
         grn_s = {N_PH{1'b0}};
      end
      if (state_s == ST_YELLOW) begin
         yel_s = onehot(phase_s);
      end else begin
         yel_s = {N_PH{1'b0}};
      end
      step_s = (state_s != state_r);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r   <= ST_ALLRED;
         phase_r   <= LAST_PH;
         remain_r  <= AR_D;
         elapsed_r <= ZERO_D;
         grn_r     <= {N_PH{1'b0}};
         yel_r     <= {N_PH{1'b0}};
         step_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         phase_r   <= phase_s;
         remain_r  <= remain_s;
         elapsed_r <= elapsed_s;
         grn_r     <= grn_s;
         yel_r     <= yel_s;
         step_r    <= step_s;
      end
   end

`ifdef TRAFFIC_PED_EN
   // Pedestrian latch, walk-service flag and WALK decode; a request coincident with clearing re-latches.
   always_comb begin
      if ((state_r == ST_YELLOW) && (state_s == ST_ALLRED)) begin
         ped_lat_s = PED_REQ;
         svc_s     = ped_lat_r;
      end else if (state_s != ST_ALLRED) begin
         ped_lat_s = ped_lat_r || PED_REQ;
         svc_s     = 1'b0;
      end else begin
         ped_lat_s = ped_lat_r || PED_REQ;
         svc_s     = svc_r;
      end
      walk_s = svc_s && (state_s == ST_ALLRED) && (remain_s <= EXT_D);
   end

   // Pedestrian registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ped_lat_r <= 1'b0;
         svc_r     <= 1'b0;
         walk_r    <= 1'b0;
      end else begin
         ped_lat_r <= ped_lat_s;
         svc_r     <= svc_s;
         walk_r    <= walk_s;
      end
   end

   assign WALK = walk_r;
`endif

   assign PHASE  = phase_r;
   assign STATE  = state_r;
   assign GRN    = grn_r;
   assign YEL    = yel_r;
   assign REMAIN = remain_r;
   assign STEP   = step_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl (default parameters).
// The pedestrian section is compiled only when TRAFFIC_PED_EN is defined.
module tb_traffic_phase_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        TICK = 1'b0;
   logic [3:0]  DEMAND = 4'b0000;
   logic [23:0] GREEN_T;
   logic [1:0]  PHASE;
   logic [1:0]  STATE;
   logic [3:0]  GRN;
   logic [3:0]  YEL;
   logic [5:0]  REMAIN;
   logic        STEP;
`ifdef TRAFFIC_PED_EN
   logic        PED_REQ = 1'b0;
   logic        WALK;
`endif

   int errors = 0;
   int checks = 0;
   int gt[4] = '{7, 5, 6, 4};

   traffic_phase_ctrl dut (
      .CLK     (CLK),
      .RST     (RST),
      .TICK    (TICK),
      .DEMAND  (DEMAND),
      .GREEN_T (GREEN_T),
`ifdef TRAFFIC_PED_EN
      .PED_REQ (PED_REQ),
      .WALK    (WALK),
`endif
      .PHASE   (PHASE),
      .STATE   (STATE),
      .GRN     (GRN),
      .YEL     (YEL),
      .REMAIN  (REMAIN),
      .STEP    (STEP)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One TICK strobe seen by exactly one rising edge; returns at the following falling edge.
   task automatic tick();
      @(negedge CLK);
      TICK = 1'b1;
      @(negedge CLK);
      TICK = 1'b0;
   endtask

   task automatic measure(input string tag, input int exp_len);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (STEP !== 1'b1 && n < 100);
      chk(tag, 32'(n), 32'(exp_len));
   endtask

   initial begin
      int cur;
      int nxt;
      GREEN_T = {6'd4, 6'd6, 6'd5, 6'd7};
      repeat (2) @(negedge CLK);
      chk("rst_state",  32'(STATE),  32'd0);
      chk("rst_phase",  32'(PHASE),  32'd3);
      chk("rst_remain", 32'(REMAIN), 32'd1);
      chk("rst_grn",    32'(GRN),    32'd0);
      chk("rst_yel",    32'(YEL),    32'd0);
      chk("rst_step",   32'(STEP),   32'd0);
      RST = 1'b0;

      tick();
      chk("first_step",  32'(STEP), 32'd1);
      chk("first_grn",   32'(GRN),  32'd1);
      @(negedge CLK);
      chk("step_pulse",  32'(STEP), 32'd0);

      // Fixed-time cycle through all four phases and back to 0.
      for (int p = 0; p < 4; p++) begin
         chk("ft_phase",  32'(PHASE),  32'(p));
         chk("ft_state",  32'(STATE),  32'd1);
         chk("ft_remain", 32'(REMAIN), 32'(gt[p]));
         measure("ft_green_len", gt[p]);
         chk("ft_ystate", 32'(STATE),  32'd2);
         chk("ft_yel",    32'(YEL),    32'd1 << p);
         chk("ft_grn_off",32'(GRN),    32'd0);
         chk("ft_yremain",32'(REMAIN), 32'd3);
         measure("ft_yel_len", 3);
         chk("ft_astate", 32'(STATE),  32'd0);
         chk("ft_lamps",  32'(GRN | YEL), 32'd0);
         measure("ft_ar_len", 1);
      end
      chk("ft_wrap_phase", 32'(PHASE), 32'd0);
      chk("ft_wrap_state", 32'(STATE), 32'd1);

      // Demand on phases 0 and 3 only: 1 and 2 are skipped.
      DEMAND = 4'b1001;
      cur = 0;
      for (int i = 0; i < 2; i++) begin
         nxt = (cur == 0) ? 3 : 0;
         measure("skip_green_len", gt[cur]);
         measure("skip_yel_len", 3);
         measure("skip_ar_len", 1);
         chk("skip_phase", 32'(PHASE), 32'(nxt));
         cur = nxt;
      end

      // Rest in green on phase 0 until phase 1 calls.
      DEMAND = 4'b0001;
      repeat (6) tick();
      chk("rest_pre_remain", 32'(REMAIN), 32'd1);
      tick();
      chk("rest_state",  32'(STATE),  32'd1);
      chk("rest_remain", 32'(REMAIN), 32'd1);
      chk("rest_step",   32'(STEP),   32'd0);
      repeat (3) tick();
      chk("rest_hold_state",  32'(STATE),  32'd1);
      chk("rest_hold_remain", 32'(REMAIN), 32'd1);
      DEMAND = 4'b0011;
      @(negedge CLK);
      chk("rest_wait_tick", 32'(STATE), 32'd1);
      tick();
      chk("rest_to_yel",  32'(STATE), 32'd2);
      chk("rest_yel_step",32'(STEP),  32'd1);
      measure("rest_yel_len", 3);
      measure("rest_ar_len", 1);
      chk("rest_next_phase", 32'(PHASE),  32'd1);
      chk("rest_next_remain",32'(REMAIN), 32'd5);

      // Zero green for phase 1; the running green keeps its loaded length.
      DEMAND = 4'b0000;
      GREEN_T[11:6] = 6'd0;
      measure("late_cfg_green_len", 5);
      measure("late_cfg_yel_len", 3);
      measure("late_cfg_ar_len", 1);
      for (int p = 2; p < 5; p++) begin
         measure("zr_green_len", gt[p % 4]);
         measure("zr_yel_len", 3);
         measure("zr_ar_len", 1);
      end
      chk("zero_phase",  32'(PHASE),  32'd1);
      chk("zero_remain", 32'(REMAIN), 32'd1);
      measure("zero_green_len", 1);
      chk("zero_to_yel", 32'(STATE), 32'd2);
      measure("zero_yel_len", 3);
      measure("zero_ar_len", 1);

      // Gap-out on phase 0 with a 20-tick green.
      GREEN_T[5:0] = 6'd20;
      measure("gap_pre_g2", 6);
      measure("gap_pre_y2", 3);
      measure("gap_pre_a2", 1);
      measure("gap_pre_g3", 4);
      measure("gap_pre_y3", 3);
      measure("gap_pre_a3", 1);
      chk("gap_phase0", 32'(PHASE),  32'd0);
      chk("gap_remain", 32'(REMAIN), 32'd20);
      DEMAND = 4'b0101;
      repeat (2) tick();
      DEMAND = 4'b0100;
      repeat (2) tick();
      chk("gap_tick4_state",  32'(STATE),  32'd1);
      chk("gap_tick4_remain", 32'(REMAIN), 32'd16);
      tick();
      chk("gap_tick5_state", 32'(STATE), 32'd2);
      chk("gap_tick5_step",  32'(STEP),  32'd1);
      measure("gap_yel_len", 3);
      measure("gap_ar_len", 1);
      chk("gap_next_phase", 32'(PHASE), 32'd2);
      chk("gap_next_grn",   32'(GRN),   32'd4);

      // Asynchronous reset mid-green, then fallback to phase 0.
      repeat (2) tick();
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("mrst_state",  32'(STATE),  32'd0);
      chk("mrst_phase",  32'(PHASE),  32'd3);
      chk("mrst_remain", 32'(REMAIN), 32'd1);
      chk("mrst_grn",    32'(GRN),    32'd0);
      chk("mrst_step",   32'(STEP),   32'd0);
      @(negedge CLK);
      RST = 1'b0;
      DEMAND = 4'b0000;
      tick();
      chk("mrst_next_phase", 32'(PHASE), 32'd0);
      chk("mrst_next_state", 32'(STATE), 32'd1);

`ifdef TRAFFIC_PED_EN
      // Pedestrian call truncates a 20-tick green at MIN_G and extends all-red with WALK.
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      tick();
      chk("ped_green_remain", 32'(REMAIN), 32'd20);
      tick();
      @(negedge CLK);
      PED_REQ = 1'b1;
      @(negedge CLK);
      PED_REQ = 1'b0;
      repeat (3) tick();
      chk("ped_tick4_state", 32'(STATE), 32'd1);
      tick();
      chk("ped_tick5_state", 32'(STATE), 32'd2);
      measure("ped_yel_len", 3);
      chk("ped_ar_remain", 32'(REMAIN), 32'd17);
      chk("ped_walk_off",  32'(WALK),   32'd0);
      tick();
      chk("ped_walk_on",   32'(WALK),   32'd1);
      chk("ped_ar_rem16",  32'(REMAIN), 32'd16);
      repeat (4) tick();
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("ped_rst_walk",   32'(WALK),   32'd0);
      chk("ped_rst_state",  32'(STATE),  32'd0);
      chk("ped_rst_remain", 32'(REMAIN), 32'd1);
      @(negedge CLK);
      RST = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL have parameter N_PH, default 4, meaning number of signal phases (legal 2..8).
REQ-002 The block SHALL have parameter CW, default 6, meaning width of every duration and countdown field.
REQ-003 The block SHALL have parameter YEL_T, default 3, meaning yellow duration in ticks.
REQ-004 The block SHALL have parameter AR_T, default 1, meaning all-red clearance duration in ticks.
REQ-005 The block SHALL have parameter MIN_G, default 5, meaning minimum green in ticks before gap-out is allowed.
REQ-006 The block SHALL have one clock, CLK  in  1  rising-edge clock.
REQ-007 The block SHALL have reset RST  in  1, asynchronous, active-high.
REQ-008 The block SHALL have input TICK  in  1, a one-cycle timing strobe (1 s in the system).
REQ-009 The block SHALL have input DEMAND  in  N_PH, a vehicle-present bit per phase.
REQ-010 The block SHALL have input GREEN_T  in  N_PH*CW, the packed green duration per phase, with phase i at bits [i*CW +: CW].
REQ-011 The block SHALL have output PHASE  out  clog2(N_PH), the index of the active phase.
REQ-012 The block SHALL have output STATE  out  2, encoded as 00 ALLRED, 01 GREEN, 10 YELLOW.
REQ-013 The block SHALL have outputs GRN and YEL  out  N_PH, one-hot lamp drives, with all other phases red.
REQ-014 The block SHALL have output REMAIN  out  CW, the ticks left in the current state.
REQ-015 The block SHALL have output STEP  out  1, a one-cycle pulse on every state transition.

Function
REQ-016 Each state SHALL load REMAIN with its duration on entry: GREEN loads GREEN_T[PHASE], YELLOW loads YEL_T, ALLRED loads AR_T; a zero duration SHALL be clamped to 1.
REQ-017 REMAIN SHALL decrement only on cycles with TICK=1; a clock edge with TICK=1 and REMAIN=1 SHALL be the expiry edge, which changes state, reloads REMAIN and asserts STEP in the following cycle.
REQ-018 Transitions SHALL occur in the order ALLRED -> GREEN -> YELLOW -> ALLRED.
REQ-019 On ALLRED expiry, the next PHASE SHALL be the first phase with DEMAND set, scanning cyclically from PHASE+1; if no phase has DEMAND set, the next PHASE SHALL be PHASE+1 mod N_PH (fixed-time fallback).
REQ-020 Rest-in-green: on GREEN expiry with no DEMAND set on any other phase, the block SHALL stay in GREEN with REMAIN held at 1 until another phase's DEMAND rises, then move to YELLOW on the next TICK.
REQ-021 Gap-out: in GREEN, when at least MIN_G ticks have elapsed, DEMAND[PHASE]=0 and any other DEMAND bit is set, the block SHALL move to YELLOW on the next TICK edge.
REQ-022 The elapsed-green counter SHALL saturate at 2^CW-1 and SHALL clear on GREEN entry.
REQ-023 GRN[PHASE] SHALL be 1 only in GREEN, YEL[PHASE] SHALL be 1 only in YELLOW, and both vectors SHALL be all-zero in ALLRED.
REQ-024 Outputs SHALL be registered, with no combinational path from any input to any output.
REQ-025 Changes to GREEN_T SHALL take effect only at the next GREEN entry.

Reset
REQ-026 While RST=1, the block SHALL hold STATE=ALLRED, PHASE=N_PH-1, REMAIN=AR_T, GRN=0, YEL=0, STEP=0, elapsed=0.
REQ-027 A reset asserted mid-operation SHALL take effect asynchronously, and the first expiry after release SHALL select a phase per REQ-019 from PHASE=N_PH-1, giving phase 0 on fallback.

Configuration
REQ-028 With macro TRAFFIC_PED_EN defined, the block SHALL add input PED_REQ (1 bit) and output WALK (1 bit).
REQ-029 With TRAFFIC_PED_EN defined, a PED_REQ pulse SHALL be latched until served; if latched during GREEN, the green SHALL be truncated to the later of MIN_G elapsed and the next TICK.
REQ-030 With TRAFFIC_PED_EN defined, the next ALLRED SHALL be extended by 2^(CW-2) ticks with WALK=1 for the extension, and the latch SHALL clear at ALLRED entry.
REQ-031 With TRAFFIC_PED_EN defined, a PED_REQ arriving in the same cycle the latch clears SHALL be latched again.
REQ-032 Without TRAFFIC_PED_EN, the ports PED_REQ and WALK SHALL be absent and behaviour SHALL be exactly REQ-016 to REQ-027.

Verification
REQ-033 Reset then fixed time (N_PH=4, GREEN_T=7/5/6/4, DEMAND=0): the bench SHALL observe phases 0,1,2,3,0 with GREEN lengths 7,5,6,4 ticks, YELLOW 3 ticks and ALLRED 1 tick each.
REQ-034 Skip: with DEMAND=4'b1001 constant, the bench SHALL observe phases alternating 0,3,0 and never 1 or 2.
REQ-035 Gap-out: in phase 0 with GREEN_T=20, drop DEMAND[0] at tick 2 with DEMAND[2]=1; the bench SHALL observe YELLOW entry at tick 5 (MIN_G) and next phase 2.
REQ-036 Rest-in-green: with DEMAND=4'b0001 only, phase 0 SHALL hold GREEN with REMAIN=1; raising DEMAND[1] SHALL cause YELLOW at the next TICK.
REQ-037 Zero duration: with GREEN_T[1]=0, phase 1 green SHALL last exactly 1 tick.
REQ-038 With TRAFFIC_PED_EN and CW=6, PED_REQ at tick 1 of a 20-tick green SHALL truncate the green at tick 5, then ALLRED SHALL last 17 ticks with WALK=1 for 16 of them; RST pulsed mid-WALK SHALL force the REQ-026 values immediately.
